// File: rtl/exp_mu_pkg.sv
// Shared types and constant helpers for the geometric exp-mu table generator.
package exp_mu_pkg;

  // Generator control states.
  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StDone
  } genState_e;

  // Round-half-up constant for a fixed-point value with `frac` fractional bits.
  function automatic logic [63:0] roundConst(input int unsigned frac);
    if (frac == 0) begin
      return 64'd0;
    end
    return 64'd1 << (frac - 1);
  endfunction

  // Largest unsigned value representable in `w` bits.
  function automatic logic [63:0] satMax(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/exp_mu_mulsat.sv
// Combinational multiply, round-half-up and saturate: next = sat((cur*mu + half) >> MU_FRAC).
// Kept separate so a pipelined DSP variant can replace it later.
module exp_mu_mulsat
  import exp_mu_pkg::*;
#(
  parameter int unsigned DATA_W  = 17,
  parameter int unsigned MU_W    = 18,
  parameter int unsigned MU_FRAC = 9
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [MU_W-1:0]   mu,
  output logic [DATA_W-1:0] next,
  output logic              sat
);

  // One spare bit so adding the rounding constant can never wrap the product.
  localparam int unsigned PW = DATA_W + MU_W + 1;
  localparam int unsigned QW = PW - MU_FRAC;

  localparam logic [PW-1:0] RND  = PW'(roundConst(MU_FRAC));
  localparam logic [QW-1:0] MAXQ = QW'(satMax(DATA_W));

  logic [PW-1:0] prod;
  logic [PW-1:0] rounded;
  logic [QW-1:0] quot;

  // Multiply, round, scale back to integer and clamp to the output range.
  always_comb begin
    prod    = PW'(cur) * PW'(mu);
    rounded = prod + RND;
    quot    = QW'(rounded >> MU_FRAC);
    sat     = (quot > MAXQ);
    next    = sat ? MAXQ[DATA_W-1:0] : quot[DATA_W-1:0];
  end

endmodule

// File: rtl/exp_mu_table_gen.sv
// Geometric table generator: streams entry[k] = S*M^k for k = 0..count-1 to a downstream
// table RAM over a valid/ready handshake, with abort, sticky saturation flag and busy status.
module exp_mu_table_gen
  import exp_mu_pkg::*;
#(
  parameter int unsigned DATA_W  = 17,
  parameter int unsigned MU_W    = 18,
  parameter int unsigned MU_FRAC = 9,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [MU_W-1:0]   iMu,
  input  logic [DATA_W-1:0] iS,
  input  logic [ADDR_W-1:0] iCount,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oValid,
  output logic              oDone,
  output logic              oBusy,
  output logic              oSat
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  // One extra bit so a zero count can be held as DEPTH.
  localparam int unsigned CNT_W = ADDR_W + 1;

  genState_e         stateQ, stateD;
  logic [DATA_W-1:0] curQ, curD;
  logic [DATA_W-1:0] nextQ, nextD;
  logic              nextSatQ, nextSatD;
  logic [ADDR_W-1:0] kQ, kD;
  logic [CNT_W-1:0]  countQ, countD;
  logic [MU_W-1:0]   muQ, muD;
  logic              satQ, satD;

  logic [DATA_W-1:0] mulCur;
  logic [MU_W-1:0]   mulMu;
  logic [DATA_W-1:0] mulNext;
  logic              mulSat;
  logic              transfer;
  logic              lastEntry;

  // At start the multiplier sees the fresh operands; while emitting it runs one entry ahead.
  exp_mu_mulsat #(
    .DATA_W  (DATA_W),
    .MU_W    (MU_W),
    .MU_FRAC (MU_FRAC)
  ) uMulSat (
    .cur  (mulCur),
    .mu   (mulMu),
    .next (mulNext),
    .sat  (mulSat)
  );

  assign transfer  = (stateQ == StEmit) && iReady;
  assign lastEntry = (({1'b0, kQ} + CNT_W'(1)) == countQ);

  // Next-state, operand latching and entry advance.
  always_comb begin
    stateD   = stateQ;
    curD     = curQ;
    nextD    = nextQ;
    nextSatD = nextSatQ;
    kD       = kQ;
    countD   = countQ;
    muD      = muQ;
    satD     = satQ;
    mulCur   = nextQ;
    mulMu    = muQ;

    unique case (stateQ)
      StIdle: begin
        mulCur = iS;
        mulMu  = iMu;
        if (iStart && !iAbort) begin
          curD     = iS;
          nextD    = mulNext;
          nextSatD = mulSat;
          muD      = iMu;
          countD   = (iCount == '0) ? CNT_W'(DEPTH) : {1'b0, iCount};
          kD       = '0;
          satD     = 1'b0;
          stateD   = StEmit;
        end
      end
      StEmit: begin
        if (iAbort) begin
          // A transfer in this cycle was already taken downstream; just stop.
          stateD = StIdle;
        end else if (transfer) begin
          if (lastEntry) begin
            stateD = StDone;
          end else begin
            kD       = kQ + ADDR_W'(1);
            curD     = nextQ;
            satD     = satQ | nextSatQ;
            nextD    = mulNext;
            nextSatD = mulSat;
          end
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // State and datapath registers with dominant synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ   <= StIdle;
      curQ     <= '0;
      nextQ    <= '0;
      nextSatQ <= 1'b0;
      kQ       <= '0;
      countQ   <= '0;
      muQ      <= '0;
      satQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      curQ     <= curD;
      nextQ    <= nextD;
      nextSatQ <= nextSatD;
      kQ       <= kD;
      countQ   <= countD;
      muQ      <= muD;
      satQ     <= satD;
    end
  end

  assign oData  = curQ;
  assign oAddr  = kQ;
  assign oValid = (stateQ == StEmit);
  assign oDone  = (stateQ == StDone);
  assign oBusy  = (stateQ != StIdle);
  assign oSat   = satQ;

endmodule

// File: tb/tb_exp_mu_table_gen.sv
// Directed self-checking bench for exp_mu_table_gen at default parameters.
module tb_exp_mu_table_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iStart;
  logic        iAbort;
  logic [17:0] iMu;
  logic [16:0] iS;
  logic [5:0]  iCount;
  logic        iReady;
  logic [16:0] oData;
  logic [5:0]  oAddr;
  logic        oValid;
  logic        oDone;
  logic        oBusy;
  logic        oSat;

  int nChecks = 0;
  int nFails  = 0;

  exp_mu_table_gen dut (
    .CLK    (CLK),
    .RST    (RST),
    .iStart (iStart),
    .iAbort (iAbort),
    .iMu    (iMu),
    .iS     (iS),
    .iCount (iCount),
    .iReady (iReady),
    .oData  (oData),
    .oAddr  (oAddr),
    .oValid (oValid),
    .oDone  (oDone),
    .oBusy  (oBusy),
    .oSat   (oSat)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [16:0] s, input logic [17:0] mu, input logic [5:0] cnt);
    iS     = s;
    iMu    = mu;
    iCount = cnt;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    nChecks++;
    if ({oValid, oDone, oBusy, oSat} !== 4'b0000) begin
      nFails++;
      $display("FAIL reset_flags: got %b, want 0000", {oValid, oDone, oBusy, oSat});
    end
    nChecks++;
    if (oData !== 17'd0 || oAddr !== 6'd0) begin
      nFails++;
      $display("FAIL reset_data: got data=%0d addr=%0d, want 0/0", oData, oAddr);
    end
    RST = 1'b0;
    step();
    nChecks++;
    if (oBusy !== 1'b0) begin
      nFails++;
      $display("FAIL idle_after_reset: busy=%b, want 0", oBusy);
    end
  endtask

  // 64 entries with growth 524/512; every entry compared against an integer model.
  task automatic test_default_run();
    longint unsigned cur;
    longint unsigned p;
    bit satM;
    bit clamp;
    cur    = 102400;
    satM   = 1'b0;
    iReady = 1'b1;
    start_run(17'd102400, 18'd524, 6'd0);
    for (int i = 0; i < 64; i++) begin
      nChecks++;
      if (oValid !== 1'b1 || oAddr !== 6'(i) || oData !== 17'(cur)) begin
        nFails++;
        $display("FAIL default_entry%0d: got v=%b a=%0d d=%0d, want v=1 a=%0d d=%0d",
                 i, oValid, oAddr, oData, i, cur);
      end
      nChecks++;
      if (oSat !== satM) begin
        nFails++;
        $display("FAIL default_sat%0d: got %b, want %b", i, oSat, satM);
      end
      if (i == 3) begin
        nChecks++;
        if (oData !== 17'd109770) begin
          nFails++;
          $display("FAIL default_hand3: got %0d, want 109770", oData);
        end
      end
      p     = (cur * 524 + 256) >> 9;
      clamp = (p > 131071);
      if (clamp) p = 131071;
      step();
      cur  = p;
      satM = satM | clamp;
    end
    nChecks++;
    if (oDone !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b1) begin
      nFails++;
      $display("FAIL default_done: got done=%b valid=%b busy=%b, want 1/0/1",
               oDone, oValid, oBusy);
    end
    step();
    nChecks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oSat !== 1'b1) begin
      nFails++;
      $display("FAIL default_idle: got done=%b busy=%b sat=%b, want 0/0/1", oDone, oBusy, oSat);
    end
  endtask

  task automatic test_saturate();
    logic [16:0] expD [4];
    expD   = '{17'd131000, 17'd131071, 17'd131071, 17'd131071};
    iReady = 1'b1;
    start_run(17'd131000, 18'd1024, 6'd4);
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (oValid !== 1'b1 || oAddr !== 6'(i) || oData !== expD[i] || oSat !== (i > 0)) begin
        nFails++;
        $display("FAIL sat_entry%0d: got a=%0d d=%0d s=%b, want a=%0d d=%0d s=%b",
                 i, oAddr, oData, oSat, i, expD[i], (i > 0));
      end
      step();
    end
    nChecks++;
    if (oDone !== 1'b1 || oSat !== 1'b1) begin
      nFails++;
      $display("FAIL sat_done: got done=%b sat=%b, want 1/1", oDone, oSat);
    end
    step();
  endtask

  // Ready pattern 1,0,0,1 repeating; entries must hold during stalls and arrive in order.
  task automatic test_backpressure();
    logic [16:0] expD [5];
    logic        pat  [4];
    int idx;
    bit doneSeen;
    expD     = '{17'd1000, 17'd500, 17'd250, 17'd125, 17'd63};
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx      = 0;
    doneSeen = 1'b0;
    iReady   = 1'b1;
    start_run(17'd1000, 18'd256, 6'd5);
    for (int c = 0; c < 40 && !doneSeen; c++) begin
      iReady = pat[c % 4];
      if (oDone === 1'b1) begin
        doneSeen = 1'b1;
      end else if (oValid === 1'b1) begin
        nChecks++;
        if (idx > 4 || oAddr !== 6'(idx) || oData !== expD[idx % 5]) begin
          nFails++;
          $display("FAIL bp_entry: got a=%0d d=%0d, want a=%0d d=%0d",
                   oAddr, oData, idx, expD[idx % 5]);
        end
        if (iReady) idx++;
      end
      if (!doneSeen) step();
    end
    nChecks++;
    if (!doneSeen || idx != 5) begin
      nFails++;
      $display("FAIL bp_count: got done=%b transfers=%0d, want 1/5", doneSeen, idx);
    end
    nChecks++;
    if (oSat !== 1'b0) begin
      nFails++;
      $display("FAIL bp_sat: got %b, want 0", oSat);
    end
    iReady = 1'b1;
    step();
  endtask

  task automatic test_abort();
    bit doneSeen;
    iReady = 1'b1;
    start_run(17'd1000, 18'd256, 6'd0);
    step();
    step();
    nChecks++;
    if (oAddr !== 6'd2 || oData !== 17'd250) begin
      nFails++;
      $display("FAIL abort_pre: got a=%0d d=%0d, want 2/250", oAddr, oData);
    end
    iReady = 1'b0;
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    nChecks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      nFails++;
      $display("FAIL abort_stop: got valid=%b busy=%b done=%b, want 0/0/0",
               oValid, oBusy, oDone);
    end
    doneSeen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (oDone === 1'b1 || oValid === 1'b1) doneSeen = 1'b1;
    end
    nChecks++;
    if (doneSeen) begin
      nFails++;
      $display("FAIL abort_quiet: got activity after abort, want none");
    end
    iReady = 1'b1;
    start_run(17'd50, 18'd1024, 6'd3);
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (oValid !== 1'b1 || oAddr !== 6'(i) || oData !== (17'd50 << i)) begin
        nFails++;
        $display("FAIL restart_entry%0d: got a=%0d d=%0d, want a=%0d d=%0d",
                 i, oAddr, oData, i, 50 << i);
      end
      step();
    end
    nChecks++;
    if (oDone !== 1'b1) begin
      nFails++;
      $display("FAIL restart_done: got %b, want 1", oDone);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    iReady = 1'b1;
    start_run(17'd131000, 18'd1024, 6'd0);
    step();
    step();
    nChecks++;
    if (oSat !== 1'b1 || oBusy !== 1'b1) begin
      nFails++;
      $display("FAIL midrun_pre: got sat=%b busy=%b, want 1/1", oSat, oBusy);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    nChecks++;
    if ({oValid, oDone, oBusy, oSat} !== 4'b0000 || oData !== 17'd0 || oAddr !== 6'd0) begin
      nFails++;
      $display("FAIL midrun_reset: got flags=%b d=%0d a=%0d, want 0000/0/0",
               {oValid, oDone, oBusy, oSat}, oData, oAddr);
    end
    step();
  endtask

  task automatic test_ignored_starts();
    logic [16:0] expD [3];
    expD   = '{17'd10, 17'd10, 17'd10};
    iReady = 1'b1;
    start_run(17'd10, 18'd512, 6'd3);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        iS     = 17'd999;
        iMu    = 18'd2000;
        iCount = 6'd1;
        iStart = 1'b1;
      end
      nChecks++;
      if (oValid !== 1'b1 || oAddr !== 6'(i) || oData !== expD[i]) begin
        nFails++;
        $display("FAIL busy_start%0d: got a=%0d d=%0d, want a=%0d d=10", i, oAddr, oData, i);
      end
      step();
      iStart = 1'b0;
    end
    nChecks++;
    if (oDone !== 1'b1) begin
      nFails++;
      $display("FAIL busy_done: got %b, want 1", oDone);
    end
    step();
    iStart = 1'b1;
    iAbort = 1'b1;
    step();
    iStart = 1'b0;
    iAbort = 1'b0;
    nChecks++;
    if (oBusy !== 1'b0 || oValid !== 1'b0) begin
      nFails++;
      $display("FAIL start_abort: got busy=%b valid=%b, want 0/0", oBusy, oValid);
    end
  endtask

  task automatic test_single_and_zero_mu();
    iReady = 1'b1;
    start_run(17'd777, 18'd700, 6'd1);
    nChecks++;
    if (oValid !== 1'b1 || oAddr !== 6'd0 || oData !== 17'd777) begin
      nFails++;
      $display("FAIL single_entry: got v=%b a=%0d d=%0d, want 1/0/777", oValid, oAddr, oData);
    end
    step();
    nChecks++;
    if (oDone !== 1'b1 || oValid !== 1'b0) begin
      nFails++;
      $display("FAIL single_done: got done=%b valid=%b, want 1/0", oDone, oValid);
    end
    step();
    nChecks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      nFails++;
      $display("FAIL single_idle: got done=%b busy=%b, want 0/0", oDone, oBusy);
    end
    start_run(17'd500, 18'd0, 6'd3);
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (oAddr !== 6'(i) || oData !== ((i == 0) ? 17'd500 : 17'd0)) begin
        nFails++;
        $display("FAIL zero_mu%0d: got a=%0d d=%0d, want a=%0d d=%0d",
                 i, oAddr, oData, i, (i == 0) ? 500 : 0);
      end
      step();
    end
    step();
  endtask

  initial begin
    RST    = 1'b1;
    iStart = 1'b0;
    iAbort = 1'b0;
    iMu    = '0;
    iS     = '0;
    iCount = '0;
    iReady = 1'b0;
    test_reset();
    test_default_run();
    test_saturate();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    test_ignored_starts();
    test_single_and_zero_mu();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
